// File: rtl/fir13_pkg.sv
// Shared types and default constants for the FIR13 decimating output stage.
package fir13_pkg;

  // FIR output sample: 8-bit two's complement.
  typedef logic signed [7:0] sample_t;

  // Controller states: idle, discarding the start-up transient, decimating.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSkip = 2'd1,
    StRun  = 2'd2
  } state_t;

  localparam int unsigned DECIM_DEF = 4;
  localparam int unsigned SKIP_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 8;

endpackage

// File: rtl/fir13_decim_fifo_if.sv
// Output stream of the decimator: valid/ready head plus FIFO occupancy.
interface fir13_decim_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  import fir13_pkg::*;

  logic                         m_valid;
  sample_t                      m_data;
  logic                         m_ready;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport master (output m_valid, output m_data, output level, input m_ready);
  modport slave  (input m_valid, input m_data, input level, output m_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count and array-read head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LvlW-1:0]  level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LvlW-1:0]  cnt_q, cnt_d;
  logic             do_pop, do_push;

  assign full  = (cnt_q == LvlW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  // Head reads as zero when empty so reset presents a clean bus.
  assign rdata = empty ? '0 : mem[rd_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PtrW'(1);
    if (do_pop)  rd_d = rd_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LvlW'(1);
      2'b01:   cnt_d = cnt_q - LvlW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/fir13_decim_fifo.sv
// Discards the FIR start-up transient, decimates the sample stream and
// buffers kept samples for a valid/ready consumer with a sticky overflow flag.
module fir13_decim_fifo
  import fir13_pkg::*;
#(
  parameter int unsigned DECIM = DECIM_DEF,
  parameter int unsigned SKIP  = SKIP_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  sample_t                 din,
  input  logic                    ovf_clr,
  output logic                    ovf,
  fir13_decim_fifo_if.master      bus
);

  localparam int unsigned SkipW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int unsigned PhW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic             push_req;
  logic             ovf_q, ovf_d;
  logic             full, empty, pop;
  logic [7:0]       head;
  logic [LvlW-1:0]  lvl;

  assign pop         = ~empty & bus.m_ready;
  assign bus.m_valid = ~empty;
  assign bus.m_data  = sample_t'(head);
  assign bus.level   = lvl;
  assign ovf         = ovf_q;

  // Controller next-state: skip counting, decimation phase, push request.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    phase_d  = phase_q;
    push_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (SKIP == 0) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          state_d = StSkip;
          skip_d  = '0;
        end
      end
      StSkip: begin
        if (skip_q == SkipW'(SKIP - 1)) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          skip_d = skip_q + SkipW'(1);
        end
      end
      StRun: begin
        push_req = (phase_q == '0);
        phase_d  = (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + PhW'(1);
      end
      default: state_d = StIdle;
    endcase
    // Dropping enable overrides everything; buffered data stays drainable.
    if (!en) begin
      state_d  = StIdle;
      skip_d   = '0;
      phase_d  = '0;
      push_req = 1'b0;
    end
  end

  // Overflow: a new drop outranks a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)             ovf_d = 1'b0;
  end

  // Controller and overflow registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      skip_q  <= '0;
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push_req),
    .wdata (din),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (lvl)
  );

endmodule

// File: tb/tb_fir13_decim_fifo.sv
// Directed bench: one DUT at DECIM=4 and one at DECIM=1, shared din/reset.
module tb_fir13_decim_fifo;
  import fir13_pkg::*;

  logic    clk = 1'b0;
  logic    n_rst, en4, en1, clr4, clr1, ovf4, ovf1;
  sample_t din;

  always #5 clk = ~clk;

  fir13_decim_fifo_if #(.DEPTH(8)) bus4 ();
  fir13_decim_fifo_if #(.DEPTH(8)) bus1 ();

  fir13_decim_fifo #(.DECIM(4), .SKIP(16), .DEPTH(8)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .en(en4), .din(din), .ovf_clr(clr4), .ovf(ovf4), .bus(bus4)
  );
  fir13_decim_fifo #(.DECIM(1), .SKIP(16), .DEPTH(8)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .en(en1), .din(din), .ovf_clr(clr1), .ovf(ovf1), .bus(bus1)
  );

  typedef struct {
    int din_v;
    int exp_data;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t alt_tab[8];
    int   seq4[5];
    int   q[$];
    int   first;

    alt_tab[0] = '{-128, -128};
    alt_tab[1] = '{127, 127};
    alt_tab[2] = '{-128, -128};
    alt_tab[3] = '{127, 127};
    alt_tab[4] = '{127, 127};
    alt_tab[5] = '{-128, -128};
    alt_tab[6] = '{-1, -1};
    alt_tab[7] = '{0, 0};
    seq4 = '{17, 21, 25, 29, 33};

    n_rst = 1'b0; en4 = 1'b0; en1 = 1'b0; clr4 = 1'b0; clr1 = 1'b0; din = '0;
    bus4.m_ready = 1'b0;
    bus1.m_ready = 1'b0;
    tick();
    tick();
    check("rst_level4", int'(bus4.level), 0);
    check("rst_valid4", int'(bus4.m_valid), 0);
    check("rst_data4", int'(bus4.m_data), 0);
    check("rst_ovf4", int'(ovf4), 0);
    check("rst_valid1", int'(bus1.m_valid), 0);
    n_rst = 1'b1;
    tick();

    // Decimate-by-4 with counter input and free-flowing consumer.
    bus4.m_ready = 1'b1; en4 = 1'b1; din = '0; first = -1; q.delete();
    for (int k = 0; k < 60 && q.size() < 5; k++) begin
      tick();
      if (bus4.m_valid) begin
        if (first < 0) first = k;
        q.push_back(int'(bus4.m_data));
      end
      din = sample_t'(k + 1);
    end
    check("t1_first_edge", first, 17);
    check("t1_count", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) check("t1_seq", q[i], seq4[i]);
    check("t1_ovf", int'(ovf4), 0);
    en4 = 1'b0;
    tick();
    tick();

    // DECIM=1 fill with consumer stalled, overflow, clear priority.
    bus1.m_ready = 1'b0; en1 = 1'b1; din = '0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (k == 16) check("t2_lvl_skip", int'(bus1.level), 0);
      if (k == 17) check("t2_lvl_first", int'(bus1.level), 1);
      din = sample_t'(k + 1);
    end
    check("t2_full_level", int'(bus1.level), 8);
    check("t2_full_ovf", int'(ovf1), 0);
    tick();
    check("t2_drop_ovf", int'(ovf1), 1);
    check("t2_drop_level", int'(bus1.level), 8);
    din = sample_t'(26); clr1 = 1'b1;
    tick();
    check("t2_clr_vs_ovf", int'(ovf1), 1);
    en1 = 1'b0;
    tick();
    check("t2_clr_alone", int'(ovf1), 0);
    clr1 = 1'b0;
    bus1.m_ready = 1'b1; q.delete();
    for (int k = 0; k < 20; k++) begin
      if (bus1.m_valid) q.push_back(int'(bus1.m_data));
      tick();
    end
    check("t2_drain_count", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) check("t2_drain_seq", q[i], 17 + i);
    check("t2_empty_valid", int'(bus1.m_valid), 0);
    check("t2_empty_level", int'(bus1.level), 0);

    // Full FIFO, push and pop in the same cycle.
    bus1.m_ready = 1'b0; en1 = 1'b1; din = '0;
    for (int k = 0; k < 25; k++) begin
      tick();
      din = sample_t'(k + 1);
    end
    bus1.m_ready = 1'b1;
    tick();
    check("t3_fullpop_level", int'(bus1.level), 8);
    check("t3_fullpop_ovf", int'(ovf1), 0);
    check("t3_fullpop_head", int'(bus1.m_data), 18);
    en1 = 1'b0; q.delete();
    for (int k = 0; k < 20; k++) begin
      if (bus1.m_valid) q.push_back(int'(bus1.m_data));
      tick();
    end
    check("t3_drain_count", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) check("t3_drain_seq", q[i], 18 + i);

    // Drop enable with three entries buffered.
    bus4.m_ready = 1'b0; en4 = 1'b1; din = '0;
    for (int k = 0; k < 26; k++) begin
      tick();
      din = sample_t'(k + 1);
    end
    check("t4_three", int'(bus4.level), 3);
    en4 = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("t4_hold_level", int'(bus4.level), 3);
    check("t4_hold_head", int'(bus4.m_data), 17);
    bus4.m_ready = 1'b1; q.delete();
    for (int k = 0; k < 10; k++) begin
      if (bus4.m_valid) q.push_back(int'(bus4.m_data));
      tick();
    end
    check("t4_drain_count", q.size(), 3);
    for (int i = 0; i < 3 && i < q.size(); i++) check("t4_drain_seq", q[i], seq4[i]);
    bus4.m_ready = 1'b0; en4 = 1'b1; din = '0;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k == 16) check("t4_reskip_lvl", int'(bus4.level), 0);
      if (k == 17) begin
        check("t4_refirst_lvl", int'(bus4.level), 1);
        check("t4_refirst_data", int'(bus4.m_data), 17);
      end
      din = sample_t'(k + 1);
    end
    en4 = 1'b0;

    // Reset with five entries buffered and overflow set.
    bus1.m_ready = 1'b0; en1 = 1'b1; din = '0;
    for (int k = 0; k < 26; k++) begin
      tick();
      din = sample_t'(k + 1);
    end
    en1 = 1'b0; bus1.m_ready = 1'b1;
    tick();
    tick();
    tick();
    bus1.m_ready = 1'b0;
    check("t5_pre_level", int'(bus1.level), 5);
    check("t5_pre_ovf", int'(ovf1), 1);
    n_rst = 1'b0;
    tick();
    check("t5_rst_level", int'(bus1.level), 0);
    check("t5_rst_valid", int'(bus1.m_valid), 0);
    check("t5_rst_ovf", int'(ovf1), 0);
    check("t5_rst_data", int'(bus1.m_data), 0);
    check("t5_rst_level4", int'(bus4.level), 0);
    n_rst = 1'b1;
    tick();

    // Extreme values pass bit-exact at DECIM=1.
    bus1.m_ready = 1'b1; en1 = 1'b1; din = '0;
    for (int k = 0; k < 17; k++) tick();
    for (int i = 0; i < 8; i++) begin
      din = sample_t'(alt_tab[i].din_v);
      tick();
      check("t6_valid", int'(bus1.m_valid), 1);
      check("t6_data", int'(bus1.m_data), alt_tab[i].exp_data);
    end
    en1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
